three_parallel_fir: RTL and testbench

- Three-parallel (block size 3) pipelined FIR filter. Consumes three consecutive 16-bit signed samples per clock and produces three filtered samples per clock.
- Built on the 3-parallel fast FIR algorithm (FFA): six sub-filters of length NTAPS/3.
- Sits in the DSP datapath after the sample source. It runs at one third of the serial sample rate.

---
 rtl/fir_pkg.sv | 49 ++++
 rtl/fir_subfilter.sv | 32 +++
 rtl/three_parallel_fir.sv | 87 ++++++++
 tb/tb_three_parallel_fir.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared widths, default taps and the coefficient helpers for the six
// sub-filters of the 3-parallel fast FIR.
package fir_pkg;
    localparam int DW    = 16;
    localparam int CW    = 16;
    localparam int OW    = 64;
    localparam int NTAPS = 99;
    localparam int SUBL  = NTAPS / 3;
    localparam int SCW   = CW + 2;
    localparam int NSUB  = 6;

    typedef logic [NTAPS-1:0][CW-1:0] coeff_arr_t;
    typedef logic [SUBL-1:0][SCW-1:0] sub_coeff_t;

    typedef enum logic [2:0] {SF_H0, SF_H1, SF_H2, SF_H01, SF_H12, SF_H012} sf_sel_e;

    // Mixed-sign default taps with both full-scale extremes present.
    function automatic coeff_arr_t gen_coeffs();
        coeff_arr_t r;
        for (int j = 0; j < NTAPS; j++)
            r[j] = CW'(j * 40503 + 7919);
        r[1]       = {1'b0, {(CW-1){1'b1}}};
        r[NTAPS-1] = {1'b1, {(CW-1){1'b0}}};
        return r;
    endfunction

    localparam coeff_arr_t COEFFS = gen_coeffs();

    // Polyphase split h(3j+m) and the pre-added sets, widened so sums never wrap.
    function automatic sub_coeff_t sub_coeffs(input coeff_arr_t h, input sf_sel_e sel);
        sub_coeff_t r;
        logic signed [SCW-1:0] c0, c1, c2;
        r = '0;
        for (int j = 0; j < SUBL; j++) begin
            c0 = SCW'(signed'(h[3*j]));
            c1 = SCW'(signed'(h[3*j+1]));
            c2 = SCW'(signed'(h[3*j+2]));
            case (sel)
                SF_H0:   r[j] = c0;
                SF_H1:   r[j] = c1;
                SF_H2:   r[j] = c2;
                SF_H01:  r[j] = c0 + c1;
                SF_H12:  r[j] = c1 + c2;
                default: r[j] = c0 + c1 + c2;
            endcase
        end
        return r;
    endfunction
endpackage

// File: rtl/fir_subfilter.sv
// Block-rate direct-form FIR of length NTAPS/3: registered delay line,
// single-cycle MAC tree, registered output.
module fir_subfilter
    import fir_pkg::*;
#(
    parameter int         IW   = DW + 2,
    parameter int         AW   = 43,
    parameter sub_coeff_t COEF = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] x,
    output logic [AW-1:0] y
);
    logic [SUBL-1:0][IW-1:0] dl;
    logic signed [AW-1:0]    acc;

    // dl[0] is the newest block-rate sample.
    always_ff @(posedge clk or negedge rst)
        if (!rst) dl <= '0;
        else      dl <= {dl[SUBL-2:0], x};

    always_comb begin
        acc = '0;
        for (int j = 0; j < SUBL; j++)
            acc = acc + signed'(AW'(signed'(dl[j]))) * signed'(AW'(signed'(COEF[j])));
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) y <= '0;
        else      y <= acc;
endmodule

// File: rtl/three_parallel_fir.sv
// Three-parallel FIR using the fast FIR algorithm: three samples in and three
// filtered samples out per clock, bit-exact with the serial convolution.
module three_parallel_fir
    import fir_pkg::*;
#(
    parameter int         DW      = fir_pkg::DW,
    parameter int         OW      = fir_pkg::OW,
    parameter coeff_arr_t COEF_SET = fir_pkg::COEFFS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic        [DW-1:0] din0,
    input  logic        [DW-1:0] din1,
    input  logic        [DW-1:0] din2,
    output logic signed [OW-1:0] dout0,
    output logic signed [OW-1:0] dout1,
    output logic signed [OW-1:0] dout2
);
    localparam int XW = DW + 2;
    localparam int AW = DW + CW + 4 + $clog2(NTAPS);

    logic signed [DW-1:0]    x0r, x1r, x2r;
    logic signed [XW-1:0]    e0, e1, e2;
    logic [NSUB-1:0][XW-1:0] xa;
    logic [NSUB-1:0][AW-1:0] p;
    logic signed [AW-1:0]    p0, p1, p2, p3, p4, p5;
    logic signed [AW-1:0]    p2d, qd, t, u, v, y0, y1, y2;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            x0r <= '0;
            x1r <= '0;
            x2r <= '0;
        end else begin
            x0r <= din0;
            x1r <= din1;
            x2r <= din2;
        end

    assign e0 = XW'(x0r);
    assign e1 = XW'(x1r);
    assign e2 = XW'(x2r);
    assign xa = {e0 + e1 + e2, e1 + e2, e0 + e1, e2, e1, e0};

    for (genvar m = 0; m < NSUB; m++) begin : g_sf
        fir_subfilter #(
            .IW   (XW),
            .AW   (AW),
            .COEF (sub_coeffs(COEF_SET, sf_sel_e'(m)))
        ) u_sf (
            .clk (clk),
            .rst (rst),
            .x   (xa[m]),
            .y   (p[m])
        );
    end

    assign p0 = signed'(p[0]);
    assign p1 = signed'(p[1]);
    assign p2 = signed'(p[2]);
    assign p3 = signed'(p[3]);
    assign p4 = signed'(p[4]);
    assign p5 = signed'(p[5]);

    // t, u: cross terms with the shared H1X1 removed; v: lane-0 direct term.
    assign t  = p4 - p1;
    assign u  = p3 - p1;
    assign v  = p0 - p2d;
    assign y0 = v + qd;
    assign y1 = u - v;
    assign y2 = p5 - u - t;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            p2d   <= '0;
            qd    <= '0;
            dout0 <= '0;
            dout1 <= '0;
            dout2 <= '0;
        end else begin
            p2d   <= p2;
            qd    <= t;
            dout0 <= OW'(y0);
            dout1 <= OW'(y1);
            dout2 <= OW'(y2);
        end
endmodule

// File: tb/tb_three_parallel_fir.sv
// Randomized and directed bench for three_parallel_fir against a serial
// convolution over the full sample history since the last reset.
module tb_three_parallel_fir;
    import fir_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic signed [15:0] din0 = '0, din1 = '0, din2 = '0;
    logic signed [63:0] dout0, dout1, dout2;

    int     n_tests = 0, n_fail = 0;
    int     h [NTAPS];
    int     xs [$];
    int     nblk = 0;
    longint sumh = 0;

    three_parallel_fir dut (
        .clk   (clk),
        .rst   (rst),
        .din0  (din0),
        .din1  (din1),
        .din2  (din2),
        .dout0 (dout0),
        .dout1 (dout1),
        .dout2 (dout2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d exp %0d", tag, got, exp);
        end
    endtask

    // y(n) = sum h(j) x(n-j), zero history before the first post-reset sample
    function automatic longint ref_y(input int n);
        longint s = 0;
        for (int j = 0; j < NTAPS; j++)
            if (n - j >= 0) s += longint'(h[j]) * longint'(xs[n-j]);
        return s;
    endfunction

    function automatic int sine_smp(input int n);
        int v;
        v = $rtoi(24000.0 * $sin(6.283185307 * real'(n) / 37.3));
        v = v + int'($urandom_range(4000)) - 2000;
        return v;
    endfunction

    // One block per edge; after edge e the outputs hold block e-3.
    task automatic step(input int a, input int b, input int c);
        int e;
        din0 = 16'(a);
        din1 = 16'(b);
        din2 = 16'(c);
        @(posedge clk);
        #1;
        xs.push_back(int'(din0));
        xs.push_back(int'(din1));
        xs.push_back(int'(din2));
        e = nblk;
        nblk++;
        chk("y0", dout0, ref_y(3*(e-3)+0));
        chk("y1", dout1, ref_y(3*(e-3)+1));
        chk("y2", dout2, ref_y(3*(e-3)+2));
    endtask

    task automatic hold_reset(input int ncyc);
        rst = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            din0 = 16'($urandom);
            din1 = 16'($urandom);
            din2 = 16'($urandom);
            @(posedge clk);
            #1;
            chk("rst_y0", dout0, 0);
            chk("rst_y1", dout1, 0);
            chk("rst_y2", dout2, 0);
        end
        rst = 1'b1;
        xs.delete();
        nblk = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1);
    end

    initial begin
        for (int j = 0; j < NTAPS; j++) begin
            h[j] = int'(signed'(COEFFS[j]));
            sumh += longint'(h[j]);
        end
        #1;
        hold_reset(3);

        // impulse on lane 0
        step(1, 0, 0);
        repeat (3) step(0, 0, 0);
        chk("imp0_h0", dout0, h[0]);
        chk("imp0_h1", dout1, h[1]);
        chk("imp0_h2", dout2, h[2]);
        repeat (33) step(0, 0, 0);
        chk("imp0_tail", dout0, 0);

        // impulse on lane 2
        hold_reset(2);
        step(0, 0, 1);
        repeat (3) step(0, 0, 0);
        chk("imp2_y0", dout0, 0);
        chk("imp2_h0", dout2, h[0]);
        step(0, 0, 0);
        chk("imp2_h1", dout0, h[1]);
        chk("imp2_h3", dout2, h[3]);
        repeat (33) step(0, 0, 0);

        // DC and full-scale steady states
        hold_reset(2);
        repeat (40) step(1000, 1000, 1000);
        chk("dc_y0", dout0, 1000 * sumh);
        chk("dc_y2", dout2, 1000 * sumh);
        repeat (40) step(-32768, -32768, -32768);
        chk("neg_y0", dout0, -32768 * sumh);
        chk("neg_y1", dout1, -32768 * sumh);
        repeat (40) step(32767, 32767, 32767);
        chk("pos_y1", dout1, 32767 * sumh);
        chk("pos_y2", dout2, 32767 * sumh);

        // asynchronous reset in the middle of a random stream
        hold_reset(2);
        repeat (50) step(int'($urandom), int'($urandom), int'($urandom));
        #3;
        rst = 1'b0;
        #1;
        chk("async_y0", dout0, 0);
        chk("async_y1", dout1, 0);
        chk("async_y2", dout2, 0);
        hold_reset(3);
        repeat (60) step(int'($urandom), int'($urandom), int'($urandom));

        // sinusoid plus noise
        hold_reset(2);
        for (int k = 0; k < 2000; k++)
            step(sine_smp(3*k), sine_smp(3*k+1), sine_smp(3*k+2));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
